// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that merges NUM_REQ beat streams into one FIFO write port.
// A requester that starts a multi-beat burst keeps the port until its last beat or MAX_BURST.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16,
    localparam int IDX_W     = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [IDX_W-1:0]              owner,
    output logic                          busy,
    output logic                          err_burst
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic [IDX_W-1:0] winner;
    logic             winner_vld;
    logic             accept;
    logic [IDX_W-1:0] next_ptr;
    logic [CNT_W-1:0] beat_next;

    // While locked only the owner is considered; otherwise rotate from rr_ptr with wrap.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        winner     = '0;
        winner_vld = 1'b0;
        idx        = 0;
        cand       = '0;
        if (state == BURST) begin
            winner     = owner;
            winner_vld = req[owner];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                cand = IDX_W'(idx);
                if (!winner_vld && req[cand]) begin
                    winner     = cand;
                    winner_vld = 1'b1;
                end
            end
        end
    end

    // Reset gates the grant path so outputs drop immediately, not at the next edge.
    always_comb begin
        accept     = winner_vld & ~fifo_full & rst;
        gnt        = accept ? (NUM_REQ'(1) << winner) : '0;
        fifo_wr_en = accept;
        fifo_din   = accept ? req_data[winner*DATA_WIDTH +: DATA_WIDTH] : '0;
        next_ptr   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
        beat_next  = beat_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            busy      <= 1'b0;
            err_burst <= 1'b0;
        end else if (accept) begin
            owner <= winner;
            case (state)
                IDLE: begin
                    if (req_last[winner]) begin
                        rr_ptr <= next_ptr;
                    end else begin
                        state    <= BURST;
                        busy     <= 1'b1;
                        beat_cnt <= CNT_W'(1);
                    end
                end
                BURST: begin
                    beat_cnt <= beat_next;
                    if (req_last[winner]) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end else if (beat_next == CNT_W'(MAX_BURST)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        rr_ptr    <= next_ptr;
                        err_burst <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
